// File: rtl/adc_capture_sequencer.sv
// ADC capture sequencer: UART-commanded (optionally edge-triggered) capture of
// NUM_SAMPLES samples into a buffer, then a paced ASCII-hex dump over UART tx.
module adc_capture_sequencer #(
    parameter int NUM_SAMPLES = 1024,
    parameter int SAMPLE_W    = 24,
    parameter int GAP_CYCLES  = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [7:0]          rx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                busy,
    output logic                done
);

    localparam int AW     = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int DIGITS = SAMPLE_W / 4;
    localparam int BW     = $clog2(DIGITS + 2);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_SAMPLES - 1);
    localparam logic [15:0]   GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] LF_IDX    = BW'(DIGITS);
    localparam logic [BW-1:0] CR_IDX    = BW'(DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_GAP,
        S_LOAD,
        S_SEND
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]       wr_idx;
    logic [AW-1:0]       rd_idx;
    logic [BW-1:0]       byte_idx;
    logic [15:0]         gap_cnt;
    logic                prev_msb;
    logic                prev_seen;
    logic                abort_pend;
    logic [SAMPLE_W-1:0] mem [NUM_SAMPLES];
    logic [SAMPLE_W-1:0] mem_q;

    logic                cmd_start, cmd_trig, cmd_abort;
    logic                trig_hit, last_write, accept, last_byte, last_sample;
    logic                mem_we;
    logic [AW-1:0]       waddr;
    logic [3:0]          nib;
    logic [7:0]          ascii;

    assign cmd_start = rx_valid && (rx_data == 8'h73 || rx_data == 8'h53);
    assign cmd_trig  = rx_valid && (rx_data == 8'h74 || rx_data == 8'h54);
    assign cmd_abort = rx_valid && (rx_data == 8'h78 || rx_data == 8'h58);

    // The first sample after arming only primes the edge detector, so a sample
    // already high when armed is not mistaken for a rising edge.
    assign trig_hit    = adc_valid && prev_seen && !prev_msb && adc_data[SAMPLE_W-1];
    assign last_write  = adc_valid && (wr_idx == LAST_IDX);
    assign accept      = (state == S_SEND) && tx_ready;
    assign last_byte   = (byte_idx == CR_IDX);
    assign last_sample = (rd_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_start)     state_nxt = S_CAPTURE;
                else if (cmd_trig) state_nxt = S_ARM;
            end
            S_ARM: begin
                if (cmd_abort)     state_nxt = S_IDLE;
                else if (trig_hit) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (cmd_abort)       state_nxt = S_IDLE;
                else if (last_write) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cmd_abort)                state_nxt = S_IDLE;
                else if (gap_cnt == GAP_LAST) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (cmd_abort) state_nxt = S_IDLE;
                else           state_nxt = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    if (abort_pend || cmd_abort)       state_nxt = S_IDLE;
                    else if (last_byte && last_sample) state_nxt = S_IDLE;
                    else                               state_nxt = S_GAP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b1;
        busy     = (state != S_IDLE);
        tx_valid = (state == S_SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            byte_idx   <= '0;
            gap_cnt    <= '0;
            prev_msb   <= 1'b0;
            prev_seen  <= 1'b0;
            abort_pend <= 1'b0;
            tx_data    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    abort_pend <= 1'b0;
                    gap_cnt    <= '0;
                    if (cmd_start) wr_idx <= '0;
                    if (cmd_trig) begin
                        prev_msb  <= 1'b0;
                        prev_seen <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (adc_valid && !cmd_abort) begin
                        prev_msb  <= adc_data[SAMPLE_W-1];
                        prev_seen <= 1'b1;
                        if (trig_hit) wr_idx <= AW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (adc_valid && !cmd_abort) begin
                        if (last_write) begin
                            wr_idx   <= '0;
                            rd_idx   <= '0;
                            byte_idx <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            wr_idx <= wr_idx + AW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) gap_cnt <= '0;
                    else                     gap_cnt <= gap_cnt + 16'd1;
                end
                S_LOAD: begin
                    tx_data <= ascii;
                end
                S_SEND: begin
                    if (cmd_abort) abort_pend <= 1'b1;
                    if (accept) begin
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (!last_sample) rd_idx <= rd_idx + AW'(1);
                            done <= last_sample && !abort_pend && !cmd_abort;
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer: write while capturing, registered read of rd_idx feeds LOAD.
    always_comb begin
        mem_we = 1'b0;
        waddr  = wr_idx;
        if (adc_valid && !cmd_abort) begin
            if (state == S_CAPTURE) mem_we = 1'b1;
            if (state == S_ARM && trig_hit) begin
                mem_we = 1'b1;
                waddr  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr] <= adc_data;
        mem_q <= mem[rd_idx];
    end

    always_comb begin
        nib = '0;
        for (int i = 0; i < DIGITS; i++)
            if (byte_idx == BW'(i)) nib = mem_q[SAMPLE_W-1-4*i -: 4];
        if (byte_idx == LF_IDX)      ascii = 8'h0A;
        else if (byte_idx == CR_IDX) ascii = 8'h0D;
        else if (nib < 4'd10)        ascii = 8'h30 + {4'h0, nib};
        else                         ascii = 8'h37 + {4'h0, nib};
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Self-checking bench: byte-stream model built from the fed samples, per-cycle
// compare of the tx handshake, pacing and done pulse, plus directed literals.
module tb_adc_capture_sequencer;
    localparam int NS = 4;
    localparam int SW = 24;
    localparam int G  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    rx_data = '0;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [7:0]    tx_data;
    logic          busy;
    logic          done;

    adc_capture_sequencer #(.NUM_SAMPLES(NS), .SAMPLE_W(SW), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] e_byte;
    logic [7:0] held;
    bit         prev_hold = 0;
    bit         prev_tv = 0;
    bit         after_acc = 0;
    bit         done_next = 0;
    int         low_run = 0;
    int         done_cnt = 0;
    string      hx = "0123456789ABCDEF";

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Model: each sample becomes its hex digits MSB-first, then LF, CR.
    function automatic void push_sample(logic [SW-1:0] s);
        logic [3:0] n;
        for (int d = SW/4 - 1; d >= 0; d--) begin
            n = s[4*d +: 4];
            exp_q.push_back(hx[n]);
        end
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("done", {31'd0, done}, {31'd0, done_next});
            if (done) done_cnt++;
            done_next = 0;
            if (tx_valid) begin
                if (prev_hold) check("tx_hold", {24'd0, tx_data}, {24'd0, held});
                if (!prev_tv && after_acc) check("gap_len", low_run, G + 1);
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                        after_acc = 0;
                    end else begin
                        e_byte = exp_q.pop_front();
                        check("tx_byte", {24'd0, tx_data}, {24'd0, e_byte});
                        log_q.push_back(tx_data);
                        if (exp_q.size() == 0) done_next = 1;
                        after_acc = (exp_q.size() != 0);
                    end
                    low_run   = 0;
                    prev_hold = 0;
                end else begin
                    prev_hold = 1;
                    held      = tx_data;
                end
            end else begin
                low_run++;
                prev_hold = 0;
            end
            prev_tv = tx_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        rx_valid = 1'b1;
        rx_data  = c;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic feed(input logic [SW-1:0] s);
        adc_valid = 1'b1;
        adc_data  = s;
        tick();
        adc_valid = 1'b0;
        tick();
    endtask

    task automatic wait_dump(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d bytes left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
        check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({name, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic start_test();
        log_q.delete();
        done_cnt = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] smp [4];
        int k;
        int bad;

        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("rx_ready", {31'd0, rx_ready}, 32'd1);

        // basic dump with first-byte latency check
        start_test();
        smp = '{24'h000000, 24'h123456, 24'hABCDEF, 24'hFFFFFF};
        foreach (smp[i]) push_sample(smp[i]);
        send_cmd(8'h73);
        check("t1_busy_cap", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) feed(smp[i]);
        adc_valid = 1'b1;
        adc_data  = smp[3];
        tick();
        adc_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (tx_valid) break;
        end
        check("t1_first_latency", k, G + 2);
        wait_dump("t1");
        check("t1_len", log_q.size(), 32);
        if (log_q.size() >= 24) begin
            check("t1_b0", {24'd0, log_q[0]}, 32'h30);
            check("t1_b5", {24'd0, log_q[5]}, 32'h30);
            check("t1_b6", {24'd0, log_q[6]}, 32'h0A);
            check("t1_b7", {24'd0, log_q[7]}, 32'h0D);
            check("t1_b16", {24'd0, log_q[16]}, 32'h41);
            check("t1_b21", {24'd0, log_q[21]}, 32'h46);
            check("t1_b22", {24'd0, log_q[22]}, 32'h0A);
            check("t1_b23", {24'd0, log_q[23]}, 32'h0D);
        end

        // triggered capture: rising MSB edge at 0x800000
        start_test();
        push_sample(24'h800000);
        push_sample(24'h000001);
        push_sample(24'h000002);
        push_sample(24'h000003);
        send_cmd(8'h54);
        check("t2_busy_arm", {31'd0, busy}, 32'd1);
        feed(24'h900000);
        feed(24'h100000);
        feed(24'h7FFFFF);
        feed(24'h800000);
        feed(24'h000001);
        feed(24'h000002);
        feed(24'h000003);
        wait_dump("t2");
        check("t2_len", log_q.size(), 32);
        if (log_q.size() >= 2) begin
            check("t2_b0", {24'd0, log_q[0]}, 32'h38);
            check("t2_b1", {24'd0, log_q[1]}, 32'h30);
        end

        // tx back-pressure for 50 cycles mid-dump
        start_test();
        smp = '{24'h0F1E2D, 24'hC3B4A5, 24'h5A5A5A, 24'h00FF00};
        foreach (smp[i]) push_sample(smp[i]);
        send_cmd(8'h73);
        foreach (smp[i]) feed(smp[i]);
        k = 0;
        while (log_q.size() < 3 && k < 500) begin tick(); k++; end
        tx_ready = 1'b0;
        k = 0;
        while (!tx_valid && k < 50) begin tick(); k++; end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!tx_valid) bad++;
        end
        check("t3_stall_valid", bad, 0);
        tx_ready = 1'b1;
        wait_dump("t3");
        check("t3_len", log_q.size(), 32);

        // abort after two samples, then restart
        start_test();
        send_cmd(8'h73);
        feed(24'h111111);
        feed(24'h222222);
        send_cmd(8'h78);
        check("t4_busy_abort", {31'd0, busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid || busy) bad++;
        end
        check("t4_quiet", bad, 0);
        smp = '{24'hA1B2C3, 24'h000010, 24'hFEDCBA, 24'h0000FF};
        foreach (smp[i]) push_sample(smp[i]);
        send_cmd(8'h73);
        foreach (smp[i]) feed(smp[i]);
        wait_dump("t4");
        check("t4_len", log_q.size(), 32);

        // second start during capture is ignored
        start_test();
        smp = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        foreach (smp[i]) push_sample(smp[i]);
        send_cmd(8'h53);
        feed(smp[0]);
        feed(smp[1]);
        send_cmd(8'h73);
        feed(smp[2]);
        feed(smp[3]);
        wait_dump("t5");
        check("t5_len", log_q.size(), 32);

        // reset asserted during SEND
        start_test();
        smp = '{24'h999999, 24'h888888, 24'h777777, 24'h666666};
        foreach (smp[i]) push_sample(smp[i]);
        tx_ready = 1'b0;
        send_cmd(8'h73);
        foreach (smp[i]) feed(smp[i]);
        k = 0;
        while (!tx_valid && k < 50) begin tick(); k++; end
        check("t6_in_send", {31'd0, tx_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        after_acc = 0;
        prev_hold = 0;
        tick();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_valid || busy) bad++;
        end
        check("t6_idle", bad, 0);
        start_test();
        smp = '{24'h13579B, 24'h2468AC, 24'hFFFFFE, 24'h000000};
        foreach (smp[i]) push_sample(smp[i]);
        send_cmd(8'h73);
        foreach (smp[i]) feed(smp[i]);
        wait_dump("t6");
        check("t6_len", log_q.size(), 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 1024, meaning samples per capture; power of two, 2..4096.
REQ-002 SHALL have parameter SAMPLE_W, default 24, meaning ADC sample width; multiple of 4, 4..32.
REQ-003 SHALL have parameter GAP_CYCLES, default 100, meaning idle clocks before each UART byte; range 1..65535.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port adc_data, input, SAMPLE_W, meaning unsigned ADC sample.
REQ-007 SHALL have port adc_valid, input, 1, meaning a one-cycle strobe qualifying adc_data.
REQ-008 SHALL have ports rx_valid (input, 1), rx_ready (output, 1) and rx_data (input, 8), meaning the UART receive handshake.
REQ-009 SHALL have ports tx_valid (output, 1), tx_ready (input, 1) and tx_data (output, 8), meaning the UART transmit handshake.
REQ-010 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, meaning a one-cycle pulse when the last byte of a dump is accepted.

Function
REQ-012 SHALL implement states IDLE, ARM, CAPTURE, GAP, LOAD, SEND.
REQ-013 SHALL drive rx_ready high in all states; a command is consumed on any cycle with rx_valid=1.
REQ-014 SHALL decode commands as follows; all other bytes are ignored:
- 0x73/0x53 ('s'/'S'): start.
- 0x74/0x54 ('t'/'T'): triggered start.
- 0x78/0x58 ('x'/'X'): abort.
REQ-015 SHALL, on 's'/'S' in IDLE, go to CAPTURE with write index 0; start commands in any other state are ignored.
REQ-016 SHALL, on 't'/'T' in IDLE, go to ARM and clear the previous-sample register.
REQ-017 SHALL, in ARM, on each adc_valid, enter CAPTURE when the previous sample MSB=0 and the current sample MSB=1; that triggering sample is stored as index 0.
REQ-018 SHALL, in CAPTURE, write adc_data to the internal buffer at the write index on each adc_valid and then increment the index.
REQ-019 SHALL go to GAP with read index 0 and byte index 0 after writing index NUM_SAMPLES-1.
REQ-020 SHALL use an inferred single-port-read buffer of NUM_SAMPLES x SAMPLE_W with 1-cycle read latency.
REQ-021 SHALL ignore adc_valid outside ARM and CAPTURE.
REQ-022 SHALL, in GAP, count GAP_CYCLES clocks, then go to LOAD for one cycle to register the read data, then go to SEND.
REQ-023 SHALL, in SEND, hold tx_valid=1 and tx_data stable until tx_ready=1.
REQ-024 SHALL send per sample SAMPLE_W/4 ASCII uppercase hex digits MSB nibble first (0-9 -> 0x30+n, A-F -> 0x37+n), then 0x0A, then 0x0D.
REQ-025 SHALL, on each accepted byte (tx_valid & tx_ready), drop tx_valid and return to GAP.
REQ-026 SHALL, after 0x0D, clear the byte index and advance the read index.
REQ-027 SHALL, after 0x0D of read index NUM_SAMPLES-1, pulse done for one cycle and go to IDLE.
REQ-028 SHALL treat abort as follows:
- In ARM, CAPTURE, GAP or LOAD: go to IDLE next cycle with no byte emitted.
- In SEND: keep tx_valid until accepted, then go to IDLE without pulsing done.
- In IDLE: no effect.
REQ-029 SHALL give abort priority when abort and the final adc_valid coincide: go to IDLE and do not enter GAP.
REQ-030 SHALL ensure indices never wrap mid-operation; each start begins at index 0.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force the following; buffer contents are not reset:
- state = IDLE.
- tx_valid, tx_data, done, busy = 0.
- all indices and the gap counter = 0.
- the previous-sample register = 0.
REQ-032 SHALL, on rst_n assertion mid-transfer, drop tx_valid immediately; after release the block waits in IDLE for a command.

Verification
REQ-033 SHALL be verified by: NUM_SAMPLES=4, SAMPLE_W=24, GAP_CYCLES=2; send 's'; feed samples 0x000000, 0x123456, 0xABCDEF, 0xFFFFFF; tx_ready=1 -> 32 bytes, first "000000\n\r", third sample "ABCDEF\n\r"; each byte preceded by 2 gap cycles plus 1 LOAD cycle; done pulses once; busy falls.
REQ-034 SHALL be verified by: send 't'; feed 0x900000, 0x100000, 0x7FFFFF, 0x800000, 0x000001, 0x000002, 0x000003 -> capture starts at 0x800000, the dump begins "800000", 0x900000 is not stored.
REQ-035 SHALL be verified by: tx_ready held 0 for 50 cycles during SEND -> tx_valid stays 1 with tx_data constant, no byte is skipped or duplicated.
REQ-036 SHALL be verified by: 'x' after 2 captured samples -> IDLE next cycle, no tx_valid, done=0; a following 's' restarts from index 0.
REQ-037 SHALL be verified by: a second 's' during CAPTURE -> ignored, sample count unchanged; and rst_n pulsed low during SEND -> tx_valid=0 that cycle, busy=0, idle until the next 's'.
